// File: rtl/lif_scheduler_pkg.sv
// Shared types and default constants for the multi-neuron LIF scheduler.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
package lif_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_THRESHOLD  = 200;
   localparam int DEF_BETA_SHIFT = 1;

   // Sweep sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } lif_state_e;

   // One extra bit over the membrane width so that leak+current never wraps.
   typedef logic [DEF_WIDTH:0] lif_acc_t;

endpackage

// File: rtl/lif_scheduler_if.sv
// Host-side bundle: current writes, membrane readback, spike event stream, status.
// Latency: not applicable (wires only).
// Backpressure: spk_valid/spk_ready handshake on the spike event stream.
interface lif_scheduler_if #(
   parameter int WIDTH = 8,
   parameter int IDW   = 2
);
   logic             tick;
   logic             cur_we;
   logic [IDW-1:0]   cur_addr;
   logic [WIDTH-1:0] cur_data;
   logic [IDW-1:0]   rd_addr;
   logic [WIDTH-1:0] rd_state;
   logic             spk_valid;
   logic [IDW-1:0]   spk_id;
   logic             spk_ready;
   logic             busy;
   logic             sweep_done;
   logic             overrun;
   logic             drop;

   // Host / testbench side.
   modport master (
      output tick, cur_we, cur_addr, cur_data, rd_addr, spk_ready,
      input  rd_state, spk_valid, spk_id, busy, sweep_done, overrun, drop
   );

   // Scheduler side.
   modport slave (
      input  tick, cur_we, cur_addr, cur_data, rd_addr, spk_ready,
      output rd_state, spk_valid, spk_id, busy, sweep_done, overrun, drop
   );
endinterface

// File: rtl/lif_scheduler_update.sv
// Shared LIF arithmetic: leak, integrate, threshold-and-subtract, saturate.
// Latency: purely combinational.
// Backpressure: none.
module lif_update
   import lif_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int BETA_SHIFT = DEF_BETA_SHIFT,
   parameter int THRESHOLD  = DEF_THRESHOLD
) (
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] next,
   output logic             spike
);

   localparam logic [WIDTH:0] TH   = (WIDTH+1)'(THRESHOLD);
   localparam logic [WIDTH:0] MAXV = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH:0] sum;
   logic [WIDTH:0] resid;

   // Leak then integrate at WIDTH+1 bits; fire and subtract; clamp to full scale.
   always_comb begin
      sum   = {1'b0, s} - ({1'b0, s} >> BETA_SHIFT) + {1'b0, c};
      spike = (sum >= TH);
      resid = spike ? (sum - TH) : sum;
      next  = (resid > MAXV) ? {WIDTH{1'b1}} : resid[WIDTH-1:0];
   end

endmodule

// File: rtl/lif_scheduler.sv
// Multi-neuron LIF scheduler: one tick sweeps the shared update datapath over all neurons in index order.
// Latency: neuron i written at edge k+1+i after tick at edge k; sweep_done one cycle after edge k+N_NEURONS; readback 1 cycle.
// Backpressure: spike IDs leave through a FIFO on spk_valid/spk_ready; a spike meeting a full FIFO is dropped (sticky drop).
module lif_scheduler
   import lif_pkg::*;
#(
   parameter int N_NEURONS  = 4,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int BETA_SHIFT = DEF_BETA_SHIFT,
   parameter int THRESHOLD  = DEF_THRESHOLD,
   parameter int FIFO_DEPTH = 4,
   parameter int IDW        = $clog2(N_NEURONS)
) (
   input  logic          clk,
   input  logic          rst,
   lif_scheduler_if.slave bus
);

   localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
   localparam logic [1:0] S_UPDATE = 2'(ST_UPDATE);
   localparam logic [1:0] S_DONE   = 2'(ST_DONE);

   localparam logic [IDW-1:0] LAST_IDX = IDW'(N_NEURONS - 1);

   // FIFO_DEPTH is a power of two, so head/tail wrap naturally at PW bits.
   localparam int             PW        = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]    DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

   logic [1:0]       fsm;
   logic [IDW-1:0]   idx;
   logic             overrun_q;

   logic [WIDTH-1:0] state_mem [N_NEURONS];
   logic [WIDTH-1:0] cur_mem   [N_NEURONS];
   logic [WIDTH-1:0] rd_state_q;

   logic [IDW-1:0]   fifo_mem  [FIFO_DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [PW:0]      count;
   logic             drop_q;

   logic [WIDTH-1:0] upd_next;
   logic             upd_spike;
   logic             in_update;
   logic             push;
   logic             pop;
   logic             accept;

   lif_update #(
      .WIDTH      (WIDTH),
      .BETA_SHIFT (BETA_SHIFT),
      .THRESHOLD  (THRESHOLD)
   ) u_update (
      .s     (state_mem[idx]),
      .c     (cur_mem[idx]),
      .next  (upd_next),
      .spike (upd_spike)
   );

   assign in_update = (fsm == S_UPDATE);
   assign push      = in_update && upd_spike;
   // A pop needs a real head entry, so push+pop on an empty FIFO is just a push.
   assign pop       = (count != '0) && bus.spk_ready;
   assign accept    = push && ((count < DEPTH_CNT) || pop);

   // Sweep sequencer; ticks seen while busy are discarded and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= S_IDLE;
         idx       <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (bus.tick && (fsm != S_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (fsm)
            S_IDLE: begin
               if (bus.tick) begin
                  fsm <= S_UPDATE;
                  idx <= '0;
               end
            end
            S_UPDATE: begin
               if (idx == LAST_IDX) begin
                  fsm <= S_DONE;
               end else begin
                  idx <= idx + IDW'(1);
               end
            end
            S_DONE: begin
               fsm <= S_IDLE;
            end
            default: begin
               fsm <= S_IDLE;
            end
         endcase
      end
   end

   // Membrane write-back and host current writes; the update reads the current value before this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            state_mem[i] <= '0;
            cur_mem[i]   <= '0;
         end
      end else begin
         if (in_update) begin
            state_mem[idx] <= upd_next;
         end
         if (bus.cur_we) begin
            cur_mem[bus.cur_addr] <= bus.cur_data;
         end
      end
   end

   // Registered readback; returns the pre-update value when the same neuron is written this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= '0;
      end else begin
         rd_state_q <= state_mem[bus.rd_addr];
      end
   end

   // Spike FIFO pointers, occupancy and sticky drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         drop_q <= 1'b0;
      end else begin
         if (accept) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         if (accept && !pop) begin
            count <= count + (PW+1)'(1);
         end else if (!accept && pop) begin
            count <= count - (PW+1)'(1);
         end
         if (push && !accept) begin
            drop_q <= 1'b1;
         end
      end
   end

   // FIFO payload storage; contents are only observable behind spk_valid, so no reset is needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_mem[tail] <= idx;
      end
   end

   assign bus.rd_state   = rd_state_q;
   assign bus.spk_valid  = (count != '0);
   assign bus.spk_id     = fifo_mem[head];
   assign bus.busy       = (fsm != S_IDLE);
   assign bus.sweep_done = (fsm == S_DONE);
   assign bus.overrun    = overrun_q;
   assign bus.drop       = drop_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: directed scenarios plus randomized sweeps against a sweep-level model.
// Latency: checks sweep latency, readback latency and FIFO ordering.
// Backpressure: holds spk_ready low during sweeps, then drains.
module tb_lif_scheduler;

   logic clk;
   logic rst;

   int passed;
   int total;

   lif_scheduler_if #(.WIDTH(8), .IDW(2)) bi  ();
   lif_scheduler_if #(.WIDTH(8), .IDW(2)) bi2 ();

   lif_scheduler #(
      .N_NEURONS(4), .WIDTH(8), .BETA_SHIFT(1), .THRESHOLD(200), .FIFO_DEPTH(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bi)
   );

   lif_scheduler #(
      .N_NEURONS(4), .WIDTH(8), .BETA_SHIFT(1), .THRESHOLD(100), .FIFO_DEPTH(4)
   ) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bi2)
   );

   always #5 clk = ~clk;

   // Sweep-level reference model for the THRESHOLD=200 instance.
   int m_state [4];
   int m_cur   [4];
   int m_q     [$];
   bit m_drop;
   int obs_q   [$];

   function automatic int lif_ref(input int s, input int c, input int th, output bit spk);
      int sum;
      sum = s - (s / 2) + c;
      spk = (sum >= th);
      if (spk) sum = sum - th;
      if (sum > 255) sum = 255;
      return sum;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_state[i] = 0;
         m_cur[i]   = 0;
      end
      m_q.delete();
      m_drop = 0;
   endtask

   task automatic model_sweep();
      bit spk;
      for (int i = 0; i < 4; i++) begin
         m_state[i] = lif_ref(m_state[i], m_cur[i], 200, spk);
         if (spk) begin
            if (m_q.size() < 4) m_q.push_back(i);
            else m_drop = 1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      bi.tick = 0;  bi.cur_we = 0;  bi.spk_ready = 0;
      bi2.tick = 0; bi2.cur_we = 0; bi2.spk_ready = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   task automatic write_cur(input int a, input int d);
      @(negedge clk);
      bi.cur_we = 1; bi.cur_addr = 2'(a); bi.cur_data = 8'(d);
      @(negedge clk);
      bi.cur_we = 0;
      m_cur[a] = d;
   endtask

   // lat = number of negedges after the tick edge until sweep_done is seen (bounded).
   task automatic run_sweep(output int lat);
      @(negedge clk);
      bi.tick = 1;
      @(negedge clk);
      bi.tick = 0;
      lat = 1;
      while (bi.sweep_done !== 1'b1 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
   endtask

   task automatic read_state(input int a, output logic [7:0] v);
      @(negedge clk);
      bi.rd_addr = 2'(a);
      @(negedge clk);
      v = bi.rd_state;
   endtask

   task automatic drain();
      obs_q.delete();
      @(negedge clk);
      bi.spk_ready = 1;
      for (int i = 0; i < 12; i++) begin
         if (bi.spk_valid !== 1'b1) break;
         obs_q.push_back(int'(bi.spk_id));
         @(negedge clk);
      end
      bi.spk_ready = 0;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      do_reset();
      total++; if (bi.rd_state !== 8'd0) $display("FAIL reset_rd_state got %0d want 0", bi.rd_state); else passed++;
      total++; if (bi.spk_valid !== 1'b0) $display("FAIL reset_spk_valid got %b want 0", bi.spk_valid); else passed++;
      total++; if (bi.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bi.busy); else passed++;
      total++; if (bi.sweep_done !== 1'b0) $display("FAIL reset_sweep_done got %b want 0", bi.sweep_done); else passed++;
      total++; if (bi.overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", bi.overrun); else passed++;
      total++; if (bi.drop !== 1'b0) $display("FAIL reset_drop got %b want 0", bi.drop); else passed++;
      read_state(3, v);
      total++; if (v !== 8'd0) $display("FAIL reset_state3 got %0d want 0", v); else passed++;
   endtask

   task automatic test_leak();
      int lat;
      logic [7:0] v;
      do_reset();
      write_cur(0, 100);
      for (int s = 1; s <= 8; s++) begin
         run_sweep(lat);
         model_sweep();
         if (s == 1) begin
            total++; if (lat !== 5) $display("FAIL leak_latency got %0d want 5", lat); else passed++;
         end
         if (s == 7) begin
            total++; if (bi.spk_valid !== 1'b0) $display("FAIL leak_no_spike_s7 got %b want 0", bi.spk_valid); else passed++;
         end
         read_state(0, v);
         total++; if (v !== 8'(m_state[0])) $display("FAIL leak_state_s%0d got %0d want %0d", s, v, m_state[0]); else passed++;
      end
      total++; if (bi.spk_valid !== 1'b1 || bi.spk_id !== 2'd0) $display("FAIL leak_event got v=%b id=%0d want v=1 id=0", bi.spk_valid, bi.spk_id); else passed++;
      drain();
      total++; if (obs_q.size() !== m_q.size()) $display("FAIL leak_event_count got %0d want %0d", obs_q.size(), m_q.size()); else passed++;
   endtask

   task automatic test_strong();
      int lat;
      logic [7:0] v;
      do_reset();
      write_cur(2, 255);
      for (int s = 1; s <= 2; s++) begin
         run_sweep(lat);
         model_sweep();
         read_state(2, v);
         total++; if (v !== 8'(m_state[2])) $display("FAIL strong_state_s%0d got %0d want %0d", s, v, m_state[2]); else passed++;
      end
      drain();
      total++; if (obs_q.size() !== m_q.size()) $display("FAIL strong_event_count got %0d want %0d", obs_q.size(), m_q.size()); else passed++;
      for (int i = 0; i < obs_q.size() && i < m_q.size(); i++) begin
         total++; if (obs_q[i] !== m_q[i]) $display("FAIL strong_event%0d got %0d want %0d", i, obs_q[i], m_q[i]); else passed++;
      end
   endtask

   task automatic test_saturation();
      int s2;
      int w;
      bit spk;
      do_reset();
      s2 = 0;
      @(negedge clk);
      bi2.cur_we = 1; bi2.cur_addr = 2'd1; bi2.cur_data = 8'd255;
      @(negedge clk);
      bi2.cur_we = 0; bi2.rd_addr = 2'd1;
      for (int s = 1; s <= 4; s++) begin
         if (s == 4) begin
            bi2.spk_ready = 1;
            repeat (6) @(negedge clk);
            bi2.spk_ready = 0;
            total++; if (bi2.spk_valid !== 1'b0) $display("FAIL sat_predrain got %b want 0", bi2.spk_valid); else passed++;
         end
         @(negedge clk);
         bi2.tick = 1;
         @(negedge clk);
         bi2.tick = 0;
         w = 0;
         while (bi2.sweep_done !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
         end
         @(negedge clk);
         s2 = lif_ref(s2, 255, 100, spk);
         total++; if (bi2.rd_state !== 8'(s2)) $display("FAIL sat_state_s%0d got %0d want %0d", s, bi2.rd_state, s2); else passed++;
      end
      total++; if (bi2.spk_valid !== spk || bi2.spk_id !== 2'd1) $display("FAIL sat_spike got v=%b id=%0d want v=%b id=1", bi2.spk_valid, bi2.spk_id, spk); else passed++;
   endtask

   task automatic test_overrun();
      int busy_cnt;
      int done_cnt;
      logic [7:0] v;
      do_reset();
      write_cur(3, 60);
      busy_cnt = 0;
      done_cnt = 0;
      @(negedge clk);
      bi.tick = 1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 2) bi.tick = 0;
         busy_cnt += int'(bi.busy);
         done_cnt += int'(bi.sweep_done);
      end
      model_sweep();
      total++; if (busy_cnt !== 5) $display("FAIL overrun_busy_cycles got %0d want 5", busy_cnt); else passed++;
      total++; if (done_cnt !== 1) $display("FAIL overrun_done_pulses got %0d want 1", done_cnt); else passed++;
      total++; if (bi.overrun !== 1'b1) $display("FAIL overrun_flag got %b want 1", bi.overrun); else passed++;
      read_state(3, v);
      total++; if (v !== 8'(m_state[3])) $display("FAIL overrun_single_sweep got %0d want %0d", v, m_state[3]); else passed++;
      total++; if (bi.overrun !== 1'b1) $display("FAIL overrun_sticky got %b want 1", bi.overrun); else passed++;
      do_reset();
      total++; if (bi.overrun !== 1'b0) $display("FAIL overrun_cleared got %b want 0", bi.overrun); else passed++;
   endtask

   task automatic test_fifo_full();
      int lat;
      do_reset();
      for (int i = 0; i < 4; i++) write_cur(i, 255);
      for (int s = 0; s < 2; s++) begin
         run_sweep(lat);
         model_sweep();
      end
      total++; if (bi.drop !== m_drop) $display("FAIL fifo_drop got %b want %b", bi.drop, m_drop); else passed++;
      drain();
      total++; if (obs_q.size() !== m_q.size()) $display("FAIL fifo_count got %0d want %0d", obs_q.size(), m_q.size()); else passed++;
      for (int i = 0; i < obs_q.size() && i < m_q.size(); i++) begin
         total++; if (obs_q[i] !== m_q[i]) $display("FAIL fifo_order%0d got %0d want %0d", i, obs_q[i], m_q[i]); else passed++;
      end
      total++; if (bi.spk_valid !== 1'b0) $display("FAIL fifo_empty_after got %b want 0", bi.spk_valid); else passed++;
   endtask

   task automatic test_reset_mid_sweep();
      int lat;
      int w;
      logic [7:0] v;
      logic [7:0] pre;
      do_reset();
      write_cur(0, 50);
      write_cur(1, 50);
      @(negedge clk);
      bi.tick = 1;
      @(negedge clk);
      bi.tick = 0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      model_reset();
      total++; if (bi.busy !== 1'b0 || bi.sweep_done !== 1'b0) $display("FAIL midrst_fsm got busy=%b done=%b want 0 0", bi.busy, bi.sweep_done); else passed++;
      total++; if (bi.spk_valid !== 1'b0 || bi.rd_state !== 8'd0) $display("FAIL midrst_outputs got v=%b rd=%0d want 0 0", bi.spk_valid, bi.rd_state); else passed++;
      total++; if (bi.overrun !== 1'b0 || bi.drop !== 1'b0) $display("FAIL midrst_flags got ov=%b dr=%b want 0 0", bi.overrun, bi.drop); else passed++;
      read_state(0, v);
      total++; if (v !== 8'd0) $display("FAIL midrst_state0 got %0d want 0", v); else passed++;
      run_sweep(lat);
      model_sweep();
      read_state(0, v);
      total++; if (v !== 8'(m_state[0])) $display("FAIL midrst_cur_cleared got %0d want %0d", v, m_state[0]); else passed++;

      write_cur(1, 40);
      run_sweep(lat);
      model_sweep();
      @(negedge clk);
      bi.tick = 1;
      bi.rd_addr = 2'd1;
      @(negedge clk);
      bi.tick = 0;
      @(negedge clk);
      bi.cur_we = 1; bi.cur_addr = 2'd1; bi.cur_data = 8'd100;
      @(negedge clk);
      bi.cur_we = 0;
      pre = bi.rd_state;
      total++; if (pre !== 8'(m_state[1])) $display("FAIL same_edge_readback got %0d want %0d", pre, m_state[1]); else passed++;
      model_sweep();
      m_cur[1] = 100;
      w = 0;
      while (bi.sweep_done !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      total++; if (bi.sweep_done !== 1'b1) $display("FAIL same_edge_done got %b want 1", bi.sweep_done); else passed++;
      read_state(1, v);
      total++; if (v !== 8'(m_state[1])) $display("FAIL same_edge_old_current got %0d want %0d", v, m_state[1]); else passed++;
      run_sweep(lat);
      model_sweep();
      read_state(1, v);
      total++; if (v !== 8'(m_state[1])) $display("FAIL same_edge_new_current got %0d want %0d", v, m_state[1]); else passed++;
   endtask

   task automatic test_random();
      int lat;
      logic [7:0] v;
      do_reset();
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < 4; i++) write_cur(i, int'($urandom_range(0, 255)));
         run_sweep(lat);
         model_sweep();
         total++; if (lat !== 5) $display("FAIL rand_latency it%0d got %0d want 5", it, lat); else passed++;
         for (int i = 0; i < 4; i++) begin
            read_state(i, v);
            total++; if (v !== 8'(m_state[i])) $display("FAIL rand_state it%0d n%0d got %0d want %0d", it, i, v, m_state[i]); else passed++;
         end
         total++; if (bi.drop !== m_drop) $display("FAIL rand_drop it%0d got %b want %b", it, bi.drop, m_drop); else passed++;
         if ($urandom_range(0, 1) == 1 || it == 7) begin
            drain();
            total++; if (obs_q.size() !== m_q.size()) $display("FAIL rand_event_count it%0d got %0d want %0d", it, obs_q.size(), m_q.size()); else passed++;
            for (int i = 0; i < obs_q.size() && i < m_q.size(); i++) begin
               total++; if (obs_q[i] !== m_q[i]) $display("FAIL rand_event it%0d e%0d got %0d want %0d", it, i, obs_q[i], m_q[i]); else passed++;
            end
            m_q.delete();
         end
      end
   endtask

   initial begin
      clk = 0;
      rst = 1;
      passed = 0;
      total = 0;
      bi.tick = 0;  bi.cur_we = 0;  bi.cur_addr = '0;  bi.cur_data = '0;  bi.rd_addr = '0;  bi.spk_ready = 0;
      bi2.tick = 0; bi2.cur_we = 0; bi2.cur_addr = '0; bi2.cur_data = '0; bi2.rd_addr = '0; bi2.spk_ready = 0;
      test_reset();
      test_leak();
      test_strong();
      test_saturation();
      test_overrun();
      test_fifo_full();
      test_reset_mid_sweep();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
